// File: rtl/ibpl_out_seq.sv
// Per-channel output pulse sequencer for the interbackplane output cardlet.
// A trigger rising edge produces a pulse after a programmable delay, with a programmable width.
module ibpl_out_seq #(
  parameter int CHANNELS = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [CNT_W-1:0]    cfg_delay,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] output_enable,
  input  logic                err_clr,
  output logic [CHANNELS-1:0] seq_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overrun,
  output logic [CHANNELS-1:0] err_sticky,
  output logic                plugin_err
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_e;

  localparam logic [3:0]       CH_LIM  = 4'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CHANNELS-1:0] trig_q;
  logic                cfg_ok;

  // Out-of-range channel indices are dropped here so no channel sees them.
  assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < CH_LIM);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) trig_q <= '0;
    else         trig_q <= trig;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [2:0] CH_IDX = 3'(gi);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] delay_reg_q;
    logic [CNT_W-1:0] width_reg_q;
    logic [CNT_W-1:0] width_lat_q;
    logic             seq_q;
    logic             busy_q;
    logic             ovr_q;
    logic             err_q;
    logic             trig_edge;
    logic             en;
    logic             cfg_hit;
    logic             ovr_d;
    logic [CNT_W-1:0] width_eff;

    assign trig_edge = trig[gi] & ~trig_q[gi];
    assign en        = output_enable[gi];
    assign cfg_hit   = cfg_ok && (cfg_ch == CH_IDX);
    assign ovr_d     = trig_edge && (state_q != S_IDLE);
    // A programmed width of zero still yields a one-cycle pulse.
    assign width_eff = (width_reg_q == '0) ? CNT_ONE : width_reg_q;

    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        delay_reg_q <= '0;
        width_reg_q <= CNT_ONE;
        width_lat_q <= CNT_ONE;
        seq_q       <= 1'b0;
        busy_q      <= 1'b0;
        ovr_q       <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        if (cfg_hit) begin
          delay_reg_q <= cfg_delay;
          width_reg_q <= cfg_width;
        end
        ovr_q <= ovr_d;
        err_q <= (err_q && !err_clr) || ovr_d;

        case (state_q)
          S_IDLE: begin
            if (trig_edge && en) begin
              // Width is captured now so later config writes only affect the next sequence.
              width_lat_q <= width_eff;
              busy_q      <= 1'b1;
              if (delay_reg_q != '0) begin
                state_q <= S_DELAY;
                cnt_q   <= delay_reg_q;
              end else begin
                state_q <= S_PULSE;
                cnt_q   <= width_eff;
                seq_q   <= 1'b1;
              end
            end
          end
          S_DELAY: begin
            if (!en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == CNT_ONE) begin
              state_q <= S_PULSE;
              cnt_q   <= width_lat_q;
              seq_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_PULSE: begin
            if (!en || cnt_q == CNT_ONE) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              seq_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            seq_q   <= 1'b0;
          end
        endcase
      end
    end

    assign seq_out[gi]    = seq_q;
    assign busy[gi]       = busy_q;
    assign overrun[gi]    = ovr_q;
    assign err_sticky[gi] = err_q;
  end

  assign plugin_err = |err_sticky;

endmodule

// File: doc/ibpl_out_seq.md
Name: ibpl_out_seq

Overview:
Per-channel output pulse sequencer for the interbackplane output cardlet. It turns trigger edges from the blackbox core into timed pulses: a programmable delay, then a programmable width. Its seq_out drives the cardlet's internal_out[5:0] path, and it respects the per-channel output_enable. It also reports busy, overrun and an error summary back to the cardlet's plugin_error logic.

Parameters:
CHANNELS, 6, number of output channels sequenced (matches the 6 DIOB lines of an output cardlet)
CNT_W, 16, width of delay/width counters and config fields

Ports:
clk  input  1  system clock
nReset  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  3  channel index for config write
cfg_delay  input  CNT_W  delay in clk cycles from trigger edge to pulse start
cfg_width  input  CNT_W  pulse width in clk cycles (0 treated as 1)
trig  input  CHANNELS  per-channel trigger level; rising edge starts a sequence
output_enable  input  CHANNELS  per-channel enable from cardlet config
err_clr  input  1  clears sticky error bits
seq_out  output  CHANNELS  registered pulse outputs to internal_out
busy  output  CHANNELS  channel in DELAY or PULSE
overrun  output  CHANNELS  one-cycle pulse: trigger edge while busy
err_sticky  output  CHANNELS  sticky overrun flags
plugin_err  output  1  OR of err_sticky

Behaviour:
- Reset (nReset low, async): seq_out=0, busy=0, overrun=0, err_sticky=0, plugin_err=0; all FSMs in IDLE; trig history=0; delay_reg=0, width_reg=1 for every channel.
- Config: on cfg_we with cfg_ch<CHANNELS, load delay_reg/width_reg[cfg_ch] at the clock edge. cfg_ch>=CHANNELS is ignored with no side effects.
- Each sequence latches delay_reg/width_reg at its start. A config write to a busy channel does not affect the running sequence; it applies to the next one.
- Edge detect: trig_q is trig registered; edge[i] = trig[i] & ~trig_q[i]. A trigger held high produces one edge only.
- Per-channel FSM, states IDLE, DELAY, PULSE:
  - IDLE: if edge and output_enable[i], go to DELAY with cnt=delay_reg when delay_reg>0, otherwise go to PULSE with cnt=max(width_reg,1). An edge with output_enable low is ignored silently.
  - DELAY: cnt decrements each cycle. On the cycle cnt==1, go to PULSE with cnt=max(width,1).
  - PULSE: seq_out high, cnt decrements. On the cycle cnt==1, go to IDLE.
- Latency: for an edge seen in cycle t, seq_out is high in cycles t+1+D through t+D+W, where D is the delay and W is the effective width.
- busy is high exactly in the DELAY and PULSE states. A new edge is accepted in the first IDLE cycle after seq_out falls, so back-to-back pulses are possible.
- An edge while in DELAY or PULSE does not restart the sequence; overrun[i] pulses high for the following cycle and err_sticky[i] sets.
- output_enable[i] dropping in DELAY or PULSE aborts to IDLE: seq_out and busy are low from the next cycle, and no error is raised.
- err_clr clears all err_sticky bits. If err_clr and a new overrun occur in the same cycle, the set wins.
- plugin_err is combinational OR of err_sticky.
- All counters are unsigned CNT_W bits with no wrap: the maximum delay is 2^CNT_W-1 and the maximum width is 2^CNT_W-1.
- Channels are fully independent. Simultaneous edges on all channels are all honoured in the same cycle.

Test Plan:
- Reset then ch0 cfg delay=3 width=2, output_enable=0x3F, trig[0] rising at cycle 10 -> seq_out[0] high in cycles 14-15 only; busy[0] high 11-15.
- ch1 delay=0 width=0, edge at cycle 20 -> seq_out[1] high in cycle 21 only; the edge in cycle 22 is accepted and seq_out[1] is high in cycle 23.
- ch2 delay=5 width=4, second edge 2 cycles after the first -> overrun[2] one-cycle pulse, err_sticky=0x04, plugin_err=1, pulse timing unchanged; err_clr -> err_sticky=0.
- ch3 running with width=100, output_enable[3] dropped at pulse cycle 10 -> seq_out[3]=0 and busy[3]=0 the next cycle, no overrun.
- cfg write to ch4 (width 8 -> 2) during an active 8-cycle pulse -> current pulse lasts 8 cycles, next pulse lasts 2; cfg_ch=7 write -> no channel changes.
- All six trig bits rise together with distinct configs -> each channel's pulses follow its own D/W independently; assert nReset mid-pulse -> all outputs 0 immediately.
